// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM encoding, command bytes, frame builder.
// Combinational only; no latency and no flow control.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  // Bits after the start bit, LSB first: D0..D7, odd parity, stop.
  function automatic logic [9:0] ps2_frame(input logic [7:0] i_byte);
    return {1'b1, ~^i_byte, i_byte};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchronises and debounces one PS/2 line; level and fall strobe lag the pin by 2+FILTER_LEN cycles.
// No backpressure: samples every cycle.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      // r_cnt counts consecutive samples that disagree with the accepted level
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift on device clock, ACK check.
// One byte per transfer; tx_start is ignored while busy or on the done/error cycle (no queueing).
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ           = 50000000,
  parameter int INHIBIT_US       = 100,
  parameter int START_TIMEOUT_US = 15000,
  parameter int XFER_TIMEOUT_US  = 2000,
  parameter int FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_nack
);

  localparam int CYC_PER_US  = CLK_HZ / 1000000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int START_CYC   = CYC_PER_US * START_TIMEOUT_US;
  localparam int XFER_CYC    = CYC_PER_US * XFER_TIMEOUT_US;
  localparam int MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int MAX_CYC     = (MAX_A > XFER_CYC) ? MAX_A : XFER_CYC;
  localparam int TW          = $clog2(MAX_CYC + 1);

  logic       w_clk_lvl, w_clk_fall, w_dat_lvl, w_unused_dat_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .i_pin(ps2_clk_in), .o_level(w_clk_lvl), .o_fall(w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .reset(reset), .i_pin(ps2_dat_in), .o_level(w_dat_lvl), .o_fall(w_unused_dat_fall)
  );

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt, w_tmr_inc;
  logic [9:0]    r_frame, w_frame_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic          r_dat_drv, w_dat_drv_nxt;
  logic          r_nack, w_nack_nxt;
  logic          w_xfer_to;

  assign w_tmr_inc = (r_tmr == '1) ? r_tmr : r_tmr + 1'b1;
  assign w_xfer_to = (r_tmr == TW'(XFER_CYC - 1));
  assign tx_nack   = r_nack;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_frame   <= '0;
      r_idx     <= '0;
      r_dat_drv <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_frame   <= w_frame_nxt;
      r_idx     <= w_idx_nxt;
      r_dat_drv <= w_dat_drv_nxt;
      r_nack    <= w_nack_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = w_tmr_inc;
    w_frame_nxt   = r_frame;
    w_idx_nxt     = r_idx;
    w_dat_drv_nxt = r_dat_drv;
    w_nack_nxt    = r_nack;
    ps2_clk_oe    = 1'b0;
    ps2_dat_oe    = 1'b0;
    tx_busy       = 1'b1;
    tx_done       = 1'b0;
    tx_error      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        tx_busy   = 1'b0;
        w_tmr_nxt = '0;
        if (tx_start) begin
          w_frame_nxt   = ps2_frame(tx_data);
          w_nack_nxt    = 1'b0;
          w_idx_nxt     = '0;
          w_dat_drv_nxt = 1'b0;
          w_state_nxt   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (r_tmr == TW'(INHIBIT_CYC - 1)) begin
          ps2_dat_oe  = 1'b1;
          w_tmr_nxt   = '0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        ps2_dat_oe = 1'b1;
        if (w_clk_fall) begin
          // The fall cycle counts as the first elapsed cycle of the transfer window.
          w_dat_drv_nxt = ~r_frame[0];
          w_idx_nxt     = 4'd1;
          w_tmr_nxt     = TW'(1);
          w_state_nxt   = ST_SEND;
        end else if (r_tmr == TW'(START_CYC - 1)) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_SEND: begin
        ps2_dat_oe = r_dat_drv;
        if (w_xfer_to) begin
          w_state_nxt = ST_ERROR;
        end else if (w_clk_fall) begin
          w_dat_drv_nxt = ~r_frame[r_idx];
          w_idx_nxt     = r_idx + 4'd1;
          if (r_idx == 4'd9) w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (w_xfer_to) begin
          w_state_nxt = ST_ERROR;
        end else if (w_clk_fall) begin
          if (!w_dat_lvl) begin
            w_state_nxt = ST_WAIT_IDLE;
          end else begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_lvl && w_dat_lvl) begin
          tx_done     = 1'b1;
          tx_busy     = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_xfer_to) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: begin
        tx_busy       = 1'b0;
        tx_error      = 1'b1;
        w_dat_drv_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out and
// the captured bits and outcomes are compared with an arithmetic frame/outcome model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int CLK_HZ      = 1000000;
  localparam int INHIBIT_US  = 100;
  localparam int START_US    = 1500;
  localparam int XFER_US     = 1200;
  localparam int INHIBIT_CYC = 100;
  localparam int START_CYC   = 1500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       tx_busy, tx_done, tx_error, tx_nack;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .START_TIMEOUT_US(START_US),
    .XFER_TIMEOUT_US(XFER_US), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_error(tx_error), .tx_nack(tx_nack)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor, sampled on the falling edge.
  int         cyc = 0, inh_cnt = 0, done_cnt = 0, err_cnt = 0;
  int         release_cyc = 0, err_cyc = 0;
  logic       prev_clk_oe = 1'b0;
  logic [2:0] err_snap = 3'b000;

  always @(negedge clk) begin
    cyc++;
    if (ps2_clk_oe) inh_cnt++;
    if (prev_clk_oe && !ps2_clk_oe) release_cyc = cyc;
    prev_clk_oe = ps2_clk_oe;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc  = cyc;
      err_snap = {ps2_clk_oe, ps2_dat_oe, tx_busy};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = ((ones % 2) == 0);
    return (11'd1 << 10) | (11'(par) << 9) | (11'(d) << 1);
  endfunction

  int dev_falls = 0;

  task automatic device(input int n_falls, input bit ack_low, input bit glitch,
                        output logic [10:0] frame, output bit req_ok);
    int half;
    half   = $urandom_range(30, 45);
    frame  = '1;
    req_ok = 1'b0;
    for (int t = 0; t < 2000 && !req_ok; t++) begin
      tick(1);
      if (!ps2_clk_oe && ps2_dat_oe) req_ok = 1'b1;
    end
    if (req_ok) begin
      tick(2);
      frame[0] = ps2_dat_in;
      for (int k = 1; k <= n_falls; k++) begin
        if (k == 11 && ack_low) dev_dat = 1'b0;
        if (glitch && k == 4) begin
          tick(10); dev_clk = 1'b0; tick(3); dev_clk = 1'b1; tick(half - 13);
        end else begin
          tick(half);
        end
        dev_clk   = 1'b0;
        dev_falls = k;
        tick(half);
        dev_clk = 1'b1;
        if (k <= 10) frame[k] = ps2_dat_in;
        if (k == 11) dev_dat = 1'b1;
      end
    end
  endtask

  task automatic do_case(input string name, input logic [7:0] d, input int n_falls,
                         input bit ack_low, input bit glitch, input bit poke);
    int          b_done, b_err, b_inh;
    logic [10:0] frame;
    bit          req_ok;
    logic        nack_at_start;
    bit          exp_done, exp_nack;
    b_done = done_cnt; b_err = err_cnt; b_inh = inh_cnt;
    dev_falls = 0;
    tx_data = d; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    nack_at_start = tx_nack;
    tx_data = 8'($urandom);
    fork
      device(n_falls, ack_low, glitch, frame, req_ok);
      if (poke) begin
        tick(250); tx_data = ~d; tx_start = 1'b1; tick(1); tx_start = 1'b0;
      end
    join
    for (int t = 0; t < 3000; t++) begin
      if (done_cnt != b_done || err_cnt != b_err) break;
      tick(1);
    end
    tick(3);
    exp_done = (n_falls == 11) && ack_low;
    exp_nack = (n_falls == 11) && !ack_low;
    check_eq({name, ".req"}, 32'(req_ok), 32'd1);
    check_eq({name, ".nack_clr"}, 32'(nack_at_start), 32'd0);
    check_eq({name, ".inhibit"}, 32'(inh_cnt - b_inh), 32'(INHIBIT_CYC));
    check_eq({name, ".done"}, 32'(done_cnt - b_done), 32'(exp_done));
    check_eq({name, ".error"}, 32'(err_cnt - b_err), 32'(!exp_done));
    check_eq({name, ".nack"}, 32'(tx_nack), 32'(exp_nack));
    check_eq({name, ".idle"}, 32'({tx_busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);
    if (n_falls == 11) check_eq({name, ".frame"}, 32'(frame), 32'(model_frame(d)));
    if (!exp_done) check_eq({name, ".err_lines"}, 32'(err_snap), 32'd0);
    if (n_falls == 0) check_eq({name, ".start_to"}, 32'(err_cyc - release_cyc), 32'(START_CYC));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    logic [10:0] frame;
    bit          req_ok;
    int          b_done, b_err;

    tick(5);
    check_eq("reset.outs", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error, tx_nack}), 32'd0);
    reset = 1'b0;
    tick(5);

    do_case("set_leds", PS2_CMD_SET_LEDS, 11, 1'b1, 1'b0, 1'b0);
    do_case("x01", 8'h01, 11, 1'b1, 1'b0, 1'b0);
    do_case("x00", 8'h00, 11, 1'b1, 1'b0, 1'b0);
    do_case("enable", PS2_CMD_ENABLE, 11, 1'b1, 1'b0, 1'b0);
    do_case("reset_cmd", PS2_CMD_RESET, 11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_case($sformatf("rand%0d", i), 8'($urandom), 11, 1'b1, 1'b0, 1'b0);
    do_case("no_clock", 8'($urandom), 0, 1'b1, 1'b0, 1'b0);
    do_case("stall5", 8'($urandom), 5, 1'b1, 1'b0, 1'b0);
    do_case("nack", 8'($urandom), 11, 1'b0, 1'b0, 1'b0);
    do_case("after_nack", 8'($urandom), 11, 1'b1, 1'b0, 1'b0);
    do_case("busy_poke", 8'($urandom), 11, 1'b1, 1'b0, 1'b1);
    do_case("glitch", 8'($urandom), 11, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of the data phase.
    b_done = done_cnt; b_err = err_cnt;
    dev_falls = 0;
    tx_data = 8'($urandom); tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    fork
      device(11, 1'b1, 1'b0, frame, req_ok);
      begin
        for (int t = 0; t < 3000 && dev_falls < 3; t++) tick(1);
        tick(5);
        check_eq("rst_mid.busy_before", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("rst_mid.outs", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error, tx_nack}), 32'd0);
        tick(3);
        reset = 1'b0;
      end
    join
    tick(200);
    check_eq("rst_mid.no_pulse", 32'({done_cnt - b_done, err_cnt - b_err}), 32'd0);
    check_eq("rst_mid.idle", 32'({tx_busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
